// File: rtl/pcm_frame_assembler.sv
// pcm_frame_assembler: packs the little-endian UART byte stream into multi-channel PCM frames for the DAC FIFO.
// Define PCM_ASM_TIMEOUT_EN to build the inter-byte timeout that drops stale partial frames and pulses resync.
module pcm_frame_assembler #(
  parameter int CHANNELS       = 2,
  parameter int SAMPLE_BITS    = 16,
  parameter int FILL_BITS      = 12,
  parameter int LOW_MARK       = 1228,
  parameter int HIGH_MARK      = 2048,
  parameter bit SIGNED_IN      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1200
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      rx_data,
  input  logic                            received,
  input  logic                            fifo_full,
  input  logic [FILL_BITS-1:0]            fill,
  output logic [CHANNELS*SAMPLE_BITS-1:0] wr_data,
  output logic                            wr_en,
  output logic                            xon,
  output logic                            overflow,
  output logic                            resync
);

  localparam int FRAME_W = CHANNELS * SAMPLE_BITS;
  localparam int BPS     = SAMPLE_BITS / 8;
  localparam int B       = CHANNELS * BPS;
  localparam int IDX_W   = (B > 1) ? $clog2(B) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(B - 1);
  localparam logic [FILL_BITS-1:0] LOW_F    = FILL_BITS'(LOW_MARK);
  localparam logic [FILL_BITS-1:0] HIGH_F   = FILL_BITS'(HIGH_MARK);

  if ((SAMPLE_BITS % 8) != 0 || SAMPLE_BITS < 8 || SAMPLE_BITS > 32 || CHANNELS < 1 ||
      LOW_MARK >= HIGH_MARK || HIGH_MARK >= (1 << FILL_BITS) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("pcm_frame_assembler: illegal parameter combination");
  end

  logic [IDX_W-1:0]   idx, eff_idx, idx_nxt;
  logic [FRAME_W-1:0] asm_q, base_asm, asm_nxt, load_word;
  logic               expire, last_byte;

`ifdef PCM_ASM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  assign expire = (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      resync <= 1'b0;
    end else begin
      resync <= expire;
      if (received || idx == '0 || expire)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign resync = 1'b0;
`endif

  // An expiry is applied before any coincident byte, so that byte lands as byte 0 of a fresh frame.
  always_comb begin
    eff_idx  = expire ? '0 : idx;
    base_asm = expire ? '0 : asm_q;
    asm_nxt  = base_asm;
    for (int k = 0; k < B; k++) begin
      if (eff_idx == IDX_W'(k))
        asm_nxt[((CHANNELS - 1 - k / BPS) * BPS + k % BPS) * 8 +: 8] = rx_data;
    end
    last_byte = (eff_idx == LAST_IDX);
    idx_nxt   = last_byte ? '0 : eff_idx + 1'b1;
    load_word = asm_nxt;
    if (SIGNED_IN) begin
      for (int c = 0; c < CHANNELS; c++)
        load_word[c * SAMPLE_BITS + SAMPLE_BITS - 1] = ~asm_nxt[c * SAMPLE_BITS + SAMPLE_BITS - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      asm_q    <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (received) begin
        idx   <= idx_nxt;
        asm_q <= asm_nxt;
        if (last_byte) begin
          wr_data <= load_word;
          if (fifo_full)
            overflow <= 1'b1;
          else
            wr_en <= 1'b1;
        end
      end else begin
        idx   <= eff_idx;
        asm_q <= base_asm;
      end
    end
  end

  // Host flow control: between the marks xon keeps its last value.
  always_ff @(posedge clk) begin
    if (reset)
      xon <= 1'b1;
    else if (fill >= HIGH_F)
      xon <= 1'b0;
    else if (fill <= LOW_F)
      xon <= 1'b1;
  end

endmodule

// File: tb/tb_pcm_frame_assembler.sv
// tb_pcm_frame_assembler: scoreboard bench for two assembler builds (2x16 signed, 4x24 unsigned).
// Expected frames come from a sample-level reference model; a negedge monitor pops and compares them.
module tb_pcm_frame_assembler;

  localparam int TO = 100;

  typedef struct {
    logic [95:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_a = '0, rx_b = '0;
  logic        rcv_a = 1'b0, rcv_b = 1'b0;
  logic        fifo_full = 1'b0;
  logic [11:0] fill = '0;
  logic [31:0] wr_data_a;
  logic [95:0] wr_data_b;
  logic        wr_en_a, wr_en_b, xon_a, xon_b, ovf_a, ovf_b, resync_a, resync_b;

  int   n_checks = 0, n_fail = 0, cyc = 0, last_cyc = 0;
  int   ovf_cyc_a = -1, ovf_cyc_b = -1;
  int   resync_cnt_a = 0, resync_cnt_b = 0, resync_cyc_a = -1;
  bit   xon_exp = 1'b1;
  exp_t q_a[$], q_b[$];
  logic [7:0] part_a[$], part_b[$];

  pcm_frame_assembler #(
    .CHANNELS(2), .SAMPLE_BITS(16), .FILL_BITS(12), .LOW_MARK(1228), .HIGH_MARK(2048),
    .SIGNED_IN(1'b1), .TIMEOUT_CYCLES(TO)
  ) dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_a), .received(rcv_a), .fifo_full(fifo_full),
    .fill(fill), .wr_data(wr_data_a), .wr_en(wr_en_a), .xon(xon_a), .overflow(ovf_a),
    .resync(resync_a)
  );

  pcm_frame_assembler #(
    .CHANNELS(4), .SAMPLE_BITS(24), .FILL_BITS(12), .LOW_MARK(1228), .HIGH_MARK(2048),
    .SIGNED_IN(1'b0), .TIMEOUT_CYCLES(TO)
  ) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_b), .received(rcv_b), .fifo_full(fifo_full),
    .fill(fill), .wr_data(wr_data_b), .wr_en(wr_en_b), .xon(xon_b), .overflow(ovf_b),
    .resync(resync_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Samples are little-endian on the wire; channel 0 ends up in the most significant field.
  function automatic logic [95:0] model_frame(input logic [7:0] b [12], input int ch,
                                              input int sb, input bit sgn);
    logic [95:0] f;
    logic [31:0] s;
    int          bps;
    f   = '0;
    bps = sb / 8;
    for (int c = 0; c < ch; c++) begin
      s = '0;
      for (int j = 0; j < bps; j++)
        s = s | (32'(b[c * bps + j]) << (8 * j));
      if (sgn)
        s = s ^ (32'd1 << (sb - 1));
      f = (f << sb) | 96'(s);
    end
    return f;
  endfunction

  function automatic bit hyst(input bit prev, input int f);
    if (f >= 2048) return 1'b0;
    if (f <= 1228) return 1'b1;
    return prev;
  endfunction

  // Drives one byte strobe (called just after a rising edge), updates the model, then idles gap cycles.
  task automatic applyStimulus(input bit sel_b, input logic [7:0] data, input bit full, input int gap);
    exp_t       e;
    logic [7:0] fb [12];
    int         nb;
    int         have;
    nb = sel_b ? 12 : 4;
    if (sel_b) begin
      rx_b = data; rcv_b = 1'b1; part_b.push_back(data); have = part_b.size();
    end else begin
      rx_a = data; rcv_a = 1'b1; part_a.push_back(data); have = part_a.size();
    end
    fifo_full = full;
    last_cyc  = cyc;
    if (have == nb) begin
      for (int i = 0; i < 12; i++) fb[i] = 8'h00;
      for (int i = 0; i < nb; i++) begin
        if (sel_b) fb[i] = part_b[i];
        else       fb[i] = part_a[i];
      end
      e.data = sel_b ? model_frame(fb, 4, 24, 1'b0) : model_frame(fb, 2, 16, 1'b1);
      e.cyc  = cyc + 1;
      if (full) begin
        if (sel_b && ovf_cyc_b < 0)  ovf_cyc_b = cyc + 1;
        if (!sel_b && ovf_cyc_a < 0) ovf_cyc_a = cyc + 1;
      end else if (sel_b) begin
        q_b.push_back(e);
      end else begin
        q_a.push_back(e);
      end
      if (sel_b) part_b.delete();
      else       part_a.delete();
    end
    @(posedge clk); #1;
    rcv_a = 1'b0; rcv_b = 1'b0; fifo_full = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyFill(input int v);
    bit nxt;
    fill = 12'(v);
    nxt  = hyst(xon_exp, v);
    @(negedge clk);
    checkOutput("xon before lag A", 96'(xon_a), 96'(xon_exp));
    @(negedge clk);
    checkOutput("xon A", 96'(xon_a), 96'(nxt));
    checkOutput("xon B", 96'(xon_b), 96'(nxt));
    xon_exp = nxt;
    @(posedge clk); #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    rcv_a = 1'b0; rcv_b = 1'b0; fifo_full = 1'b0;
    part_a.delete(); part_b.delete(); q_a.delete(); q_b.delete();
    ovf_cyc_a = -1; ovf_cyc_b = -1;
    @(posedge clk); #1;
    reset   = 1'b0;
    fill    = '0;
    xon_exp = 1'b1;
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    checkOutput("reset wr_data A", 96'(wr_data_a), 96'(0));
    checkOutput("reset wr_data B", wr_data_b, 96'(0));
    checkOutput("reset wr_en A", 96'(wr_en_a), 96'(0));
    checkOutput("reset xon A", 96'(xon_a), 96'(1));
    checkOutput("reset xon B", 96'(xon_b), 96'(1));
    checkOutput("reset overflow A", 96'(ovf_a), 96'(0));
    checkOutput("reset overflow B", 96'(ovf_b), 96'(0));
    checkOutput("reset resync A", 96'(resync_a), 96'(0));
    @(posedge clk); #1;
  endtask

  // Monitor: every expected frame must appear exactly in its cycle, and nothing else may strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (q_a.size() != 0 && q_a[0].cyc == cyc) begin
        e = q_a.pop_front();
        checkOutput("wr_en strobe A", 96'(wr_en_a), 96'(1));
        checkOutput("frame data A", 96'(wr_data_a), e.data);
      end else if (wr_en_a) begin
        checkOutput("unexpected wr_en A", 96'(wr_en_a), 96'(0));
      end
      if (q_b.size() != 0 && q_b[0].cyc == cyc) begin
        e = q_b.pop_front();
        checkOutput("wr_en strobe B", 96'(wr_en_b), 96'(1));
        checkOutput("frame data B", wr_data_b, e.data);
      end else if (wr_en_b) begin
        checkOutput("unexpected wr_en B", 96'(wr_en_b), 96'(0));
      end
      checkOutput("overflow A", 96'(ovf_a), 96'(ovf_cyc_a >= 0 && cyc >= ovf_cyc_a));
      checkOutput("overflow B", 96'(ovf_b), 96'(ovf_cyc_b >= 0 && cyc >= ovf_cyc_b));
      if (resync_a) begin
        resync_cnt_a++;
        resync_cyc_a = cyc;
      end
      if (resync_b) resync_cnt_b++;
    end
  end

  initial begin
    int t0, waited, exp_resync_a;
    logic [7:0] seq_a [4];
    seq_a[0] = 8'h34; seq_a[1] = 8'h12; seq_a[2] = 8'h78; seq_a[3] = 8'h56;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values();

    $display("[TB] directed frames");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, seq_a[i], 1'b0, 1);
    for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 8'(i), 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] overflow on a full FIFO");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'(8'hA0 + i), (i == 3), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'(8'hC0 + i), 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] fill hysteresis");
    applyFill(0); applyFill(2048); applyFill(1229); applyFill(1228);
    for (int i = 0; i < 16; i++) applyFill(int'($urandom_range(1000, 2300)));
    applyFill(0);

`ifdef PCM_ASM_TIMEOUT_EN
    $display("[TB] inter-byte timeout");
    applyStimulus(1'b0, 8'h11, 1'b0, 0);
    applyStimulus(1'b0, 8'h22, 1'b0, 0);
    t0 = last_cyc;
    part_a.delete();
    waited = 0;
    while (resync_cnt_a == 0 && waited < 3 * TO) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("resync after idle", 96'(resync_cnt_a), 96'(1));
    checkOutput("resync timing", 96'(resync_cyc_a), 96'(t0 + TO + 2));
    applyStimulus(1'b0, 8'hAA, 1'b0, 1);
    applyStimulus(1'b0, 8'hBB, 1'b0, 1);
    applyStimulus(1'b0, 8'hCC, 1'b0, 1);
    applyStimulus(1'b0, 8'hDD, 1'b0, 1);
    applyStimulus(1'b0, 8'h5A, 1'b0, 0);
    t0 = last_cyc;
    while (cyc < t0 + TO + 1) begin
      @(posedge clk); #1;
    end
    part_a.delete();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 8'(i), 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("resync on coincident byte", 96'(resync_cnt_a), 96'(2));
    exp_resync_a = 2;
`else
    t0 = 0; waited = 0;
    exp_resync_a = 0;
`endif

    $display("[TB] randomized frames");
    for (int f = 0; f < 150; f++) begin
      bit sel;
      sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < (sel ? 12 : 4); i++)
        applyStimulus(sel, 8'($urandom), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 2)));
    end
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] reset mid-frame");
    applyFill(2048);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'(8'h70 + i), 1'b0, 1);
    applyReset();
    check_reset_values();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'(8'h90 + i), 1'b0, 1);
    repeat (4) begin @(posedge clk); #1; end

    checkOutput("pending frames A", 96'(q_a.size()), 96'(0));
    checkOutput("pending frames B", 96'(q_b.size()), 96'(0));
    checkOutput("resync pulses A", 96'(resync_cnt_a), 96'(exp_resync_a));
    checkOutput("resync pulses B", 96'(resync_cnt_b), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
